// File: rtl/timer_irq_bridge.sv
// timer_irq_bridge: CPU bus decode to NDEV timers plus an edge-capturing, fixed-priority interrupt controller
module timer_irq_bridge #(
    parameter int          NDEV     = 2,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter logic [31:0] PIC_BASE = 32'h0000_7F80
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic                 cpu_we_i,
    input  logic                 cpu_re_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_hit_o,
    output logic [1:0]           dev_addr_o,
    output logic [31:0]          dev_wdata_o,
    output logic [NDEV-1:0]      dev_we_o,
    input  logic [32*NDEV-1:0]   dev_rdata_i,
    input  logic [NDEV-1:0]      dev_irq_i,
    output logic                 irq_o,
    output logic [2:0]           irq_id_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e          state_q, state_d;
    logic [NDEV-1:0] irq_q, mask_q, mask_d, pend_q, pend_d;
    logic [NDEV-1:0] sel, rise, w1c, ack, elig_q, elig_d;
    logic [2:0]      id_q, id_d, isv_q, isv_d;
    logic            req_q, req_d;
    logic            pic_sel, pic_we, vec_rd, eoi_wr;
    logic            unused_addr;

    function automatic logic [2:0] pick(input logic [NDEV-1:0] v);
        pick = 3'd0;
        for (int k = NDEV - 1; k >= 0; k--) if (v[k]) pick = 3'(k);
    endfunction

    for (genvar k = 0; k < NDEV; k++) begin : g_dec
        localparam logic [31:0] B = DEV_BASE + 32'(16 * k);
        assign sel[k] = cpu_addr_i[31:4] == B[31:4];
    end

    assign pic_sel     = cpu_addr_i[31:4] == PIC_BASE[31:4];
    assign cpu_hit_o   = pic_sel | (|sel);
    assign dev_addr_o  = cpu_addr_i[3:2];
    assign dev_wdata_o = cpu_wdata_i;
    assign dev_we_o    = sel & {NDEV{cpu_we_i}};
    assign pic_we      = pic_sel & cpu_we_i;
    assign vec_rd      = pic_sel & cpu_re_i & (cpu_addr_i[3:2] == 2'd2);
    assign eoi_wr      = pic_we & (cpu_addr_i[3:2] == 2'd3);
    assign irq_o       = req_q;
    assign irq_id_o    = id_q;
    assign unused_addr = ^cpu_addr_i[1:0];

    // Read-data mux: selected device word or controller register, zero when unmapped
    always_comb begin
        cpu_rdata_o = '0;
        for (int k = 0; k < NDEV; k++) if (sel[k]) cpu_rdata_o = dev_rdata_i[32*k +: 32];
        if (pic_sel)
            cpu_rdata_o = cpu_addr_i[3:2] == 2'd0 ? 32'(mask_q) :
                          cpu_addr_i[3:2] == 2'd1 ? 32'(pend_q) :
                          cpu_addr_i[3:2] == 2'd2 ? {28'b0, req_q, id_q} : 32'b0;
    end

    // Mask/pending update: a new rising edge always beats a same-cycle W1C or acknowledge
    always_comb begin
        rise   = dev_irq_i & ~irq_q;
        w1c    = (pic_we && cpu_addr_i[3:2] == 2'd1) ? cpu_wdata_i[NDEV-1:0] : '0;
        ack    = '0;
        for (int k = 0; k < NDEV; k++) ack[k] = state_q == REQ && vec_rd && id_q == 3'(k);
        mask_d = (pic_we && cpu_addr_i[3:2] == 2'd0) ? cpu_wdata_i[NDEV-1:0] : mask_q;
        pend_d = (pend_q & ~(w1c | ack)) | rise;
        elig_q = pend_q & mask_q;
        elig_d = pend_d & mask_d;
    end

    // Request FSM: raise on registered eligibility, drop as soon as the next state has none left
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        isv_d   = isv_q;
        case (state_q)
            IDLE: if (|elig_q) begin
                state_d = REQ;
                req_d   = 1'b1;
                id_d    = pick(elig_q);
            end
            REQ: if (vec_rd) begin
                state_d = SERVICE;
                req_d   = 1'b0;
                isv_d   = id_q;
            end else if (!(|elig_d)) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end else begin
                id_d    = pick(elig_d);
            end
            SERVICE: if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            irq_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            id_q    <= 3'd0;
            isv_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            irq_q   <= dev_irq_i;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            id_q    <= id_d;
            isv_q   <= isv_d;
        end
    end
endmodule

// File: tb/tb_timer_irq_bridge.sv
// tb_timer_irq_bridge: directed checks of decode, edge capture, priority, ack/EOI and async reset
module tb_timer_irq_bridge;
    logic        clk = 0, rst = 1;
    logic [31:0] addr = 0, wdata = 0;
    logic        we = 0, re = 0;
    logic [31:0] rdata, dev_wdata;
    logic        hit, irq;
    logic [1:0]  dev_addr, dev_we, dev_irq = 0;
    logic [63:0] dev_rdata = 64'hDEADBEEF_12345678;
    logic [2:0]  irq_id;
    int          passed = 0, total = 0;

    timer_irq_bridge dut (
        .clk_i(clk), .rst_i(rst), .cpu_addr_i(addr), .cpu_wdata_i(wdata),
        .cpu_we_i(we), .cpu_re_i(re), .cpu_rdata_o(rdata), .cpu_hit_o(hit),
        .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata), .dev_we_o(dev_we),
        .dev_rdata_i(dev_rdata), .dev_irq_i(dev_irq), .irq_o(irq), .irq_id_o(irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        addr = a; wdata = d; we = w; re = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we = 0; re = 0;
    endtask

    initial begin
        step(); step();
        chk("rst_irq", irq, 0);
        chk("rst_id", irq_id, 0);
        acc(32'h7F80, 0, 0, 0);
        chk("rst_mask", rdata, 0);
        rst = 0;
        step();

        acc(32'h7F00, 32'h9, 1, 0);
        chk("wr0_we", dev_we, 2'b01);
        chk("wr0_addr", dev_addr, 0);
        chk("wr0_wdata", dev_wdata, 32'h9);
        chk("wr0_hit", hit, 1);
        step();
        acc(32'h7F04, 32'h5, 1, 0);
        chk("wr1_we", dev_we, 2'b01);
        chk("wr1_addr", dev_addr, 1);
        step();
        acc(32'h7F10, 32'h7, 1, 0);
        chk("wr_dev1_we", dev_we, 2'b10);
        step();
        acc(32'h7F14, 0, 0, 1);
        chk("rd_dev1", rdata, 32'hDEADBEEF);
        step();
        acc(32'h7F04, 0, 0, 1);
        chk("rd_dev0", rdata, 32'h12345678);
        step();

        acc(32'h7F80, 3, 1, 0);
        step();
        acc(32'h7F80, 0, 0, 1);
        chk("mask_rd", rdata, 3);
        dev_irq = 2'b01;
        step();
        chk("lat1_irq", irq, 0);
        acc(32'h7F84, 0, 0, 1);
        chk("lat1_pend", rdata, 1);
        step();
        chk("lat2_irq", irq, 1);
        chk("lat2_id", irq_id, 0);
        acc(32'h7F88, 0, 0, 1);
        chk("vec0", rdata, 32'h8);
        step();
        chk("ack_irq", irq, 0);
        acc(32'h7F84, 0, 0, 1);
        chk("ack_pend", rdata, 0);
        acc(32'h7F8C, 0, 1, 0);
        step();
        step();
        chk("eoi_idle", irq, 0);
        dev_irq = 2'b00;
        step();

        dev_irq = 2'b11;
        step(); step();
        chk("both_irq", irq, 1);
        chk("both_id0", irq_id, 0);
        acc(32'h7F88, 0, 0, 1);
        chk("both_vec0", rdata, 32'h8);
        step();
        chk("svc_irq0", irq, 0);
        step();
        chk("svc_irq1", irq, 0);
        acc(32'h7F8C, 0, 1, 0);
        step();
        chk("eoi_edge1", irq, 0);
        step();
        chk("eoi_edge2_irq", irq, 1);
        chk("eoi_edge2_id", irq_id, 1);
        acc(32'h7F88, 0, 0, 1);
        chk("vec1", rdata, 32'h9);
        step();
        acc(32'h7F8C, 0, 1, 0);
        step();
        dev_irq = 2'b00;
        step();

        acc(32'h7F80, 0, 1, 0);
        step();
        dev_irq = 2'b10;
        step(); step();
        chk("masked_irq", irq, 0);
        acc(32'h7F84, 0, 0, 1);
        chk("masked_pend", rdata, 2);
        acc(32'h7F80, 2, 1, 0);
        step();
        chk("unmask_e1", irq, 0);
        step();
        chk("unmask_e2_irq", irq, 1);
        chk("unmask_e2_id", irq_id, 1);
        acc(32'h7F84, 2, 1, 0);
        step();
        chk("w1c_drop", irq, 0);
        dev_irq = 2'b00;
        step();

        acc(32'h7F80, 3, 1, 0);
        step();
        dev_irq = 2'b01;
        step(); step();
        chk("t5_irq", irq, 1);
        acc(32'h7F88, 0, 0, 1);
        step();
        dev_irq = 2'b00;
        step();
        dev_irq = 2'b01;
        step();
        chk("svc_accum_irq", irq, 0);
        acc(32'h7F84, 0, 0, 1);
        chk("svc_accum_pend", rdata, 1);
        acc(32'h7F84, 1, 1, 0);
        step();
        acc(32'h7F84, 0, 0, 1);
        chk("w1c_clear", rdata, 0);
        dev_irq = 2'b00;
        step();
        dev_irq = 2'b01;
        acc(32'h7F84, 1, 1, 0);
        step();
        acc(32'h7F84, 0, 0, 1);
        chk("set_beats_w1c", rdata, 1);
        chk("set_beats_irq", irq, 0);
        acc(32'h7F8C, 0, 1, 0);
        step();
        chk("t5_eoi_e1", irq, 0);
        step();
        chk("t5_eoi_e2_irq", irq, 1);
        chk("t5_eoi_e2_id", irq_id, 0);
        acc(32'h7F88, 0, 0, 1);
        chk("t5_vec", rdata, 32'h8);
        step();

        #2 rst = 1;
        #1;
        chk("arst_irq", irq, 0);
        chk("arst_id", irq_id, 0);
        acc(32'h7F80, 0, 0, 0);
        chk("arst_mask", rdata, 0);
        acc(32'h7F84, 0, 0, 0);
        chk("arst_pend", rdata, 0);
        rst = 0;
        dev_irq = 2'b00;
        step();

        acc(32'h7F40, 32'hFFFF_FFFF, 1, 1);
        chk("unmap_hit", hit, 0);
        chk("unmap_rdata", rdata, 0);
        chk("unmap_we", dev_we, 0);
        step();
        acc(32'h7F20, 32'hFFFF_FFFF, 1, 1);
        chk("ndev_edge_hit", hit, 0);
        chk("ndev_edge_we", dev_we, 0);
        step();
        acc(32'h7F80, 0, 0, 1);
        chk("unmap_nomask", rdata, 0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
